// File: rtl/serial_mag_cmp_if.sv
// Start/busy/done handshake and result flags of the bit-serial magnitude comparator.
//   start        : request, sampled only while busy=0
//   left, right  : operands A and B, sampled on the accepting edge
//   busy         : comparison in progress
//   done         : one-cycle pulse, result flags just updated
//   left_greater / equal / left_smaller : one-hot result of the last completed comparison
interface serial_mag_cmp_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] left;
  logic [WIDTH-1:0] right;
  logic             busy;
  logic             done;
  logic             left_greater;
  logic             equal;
  logic             left_smaller;

  modport master (
    output start, left, right,
    input  busy, done, left_greater, equal, left_smaller
  );

  modport slave (
    input  start, left, right,
    output busy, done, left_greater, equal, left_smaller
  );
endinterface

// File: rtl/serial_mag_cmp.sv
// Bit-serial magnitude comparator: latches two WIDTH-bit operands on start and
// compares them MSB-first, one bit per clock, reporting registered one-hot flags.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : serial_mag_cmp_if.slave (start/left/right in; busy/done/flags out)
// Parameters: WIDTH (>= 2), SIGNED (two's complement when nonzero),
//             EARLY_EXIT (stop at first differing bit when nonzero).
module serial_mag_cmp #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SIGNED     = 0,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_mag_cmp_if.slave bus
);

  localparam int unsigned IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WIDTH - 1);
  localparam bit SGN   = (SIGNED != 0);
  localparam bit EARLY = (EARLY_EXIT != 0);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDX_W-1:0] r_idx;
  logic             r_dec_valid;
  logic             r_dec_gt;
  logic             r_done;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic w_bit_a;
  logic w_bit_b;
  logic w_diff;
  logic w_first;
  logic w_last;
  logic w_a_gt;
  logic w_finish;
  logic w_have;
  logic w_sel_gt;
  logic w_load;
  logic w_step;
  logic w_complete;
  logic w_res_gt;
  logic w_res_eq;
  logic w_res_lt;

  // Current-bit decision; on the sign bit of a signed compare a 1 means smaller.
  assign w_bit_a  = r_a[WIDTH-1];
  assign w_bit_b  = r_b[WIDTH-1];
  assign w_diff   = w_bit_a ^ w_bit_b;
  assign w_first  = (r_idx == IDX_TOP);
  assign w_last   = (r_idx == '0);
  assign w_a_gt   = (SGN && w_first) ? w_bit_b : w_bit_a;
  assign w_finish = EARLY ? (w_diff || w_last) : w_last;
  // An earlier stored difference always wins over the current bit.
  assign w_have   = r_dec_valid || w_diff;
  assign w_sel_gt = r_dec_valid ? r_dec_gt : w_a_gt;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_SCAN;
      S_SCAN:  if (w_finish)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Control strobes and completion result.
  always_comb begin
    w_load     = 1'b0;
    w_step     = 1'b0;
    w_complete = 1'b0;
    w_res_gt   = w_have && w_sel_gt;
    w_res_lt   = w_have && !w_sel_gt;
    w_res_eq   = !w_have;
    case (r_state)
      S_IDLE:  w_load = bus.start;
      S_SCAN: begin
        if (w_finish) w_complete = 1'b1;
        else          w_step     = 1'b1;
      end
      default: ;
    endcase
  end

  // Shift registers, bit index, sticky decision and result flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_idx       <= '0;
      r_dec_valid <= 1'b0;
      r_dec_gt    <= 1'b0;
      r_done      <= 1'b0;
      r_gt        <= 1'b0;
      r_eq        <= 1'b0;
      r_lt        <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (w_load) begin
        r_a         <= bus.left;
        r_b         <= bus.right;
        r_idx       <= IDX_TOP;
        r_dec_valid <= 1'b0;
        r_dec_gt    <= 1'b0;
      end else if (w_step) begin
        r_a   <= {r_a[WIDTH-2:0], 1'b0};
        r_b   <= {r_b[WIDTH-2:0], 1'b0};
        r_idx <= r_idx - IDX_W'(1);
        if (w_diff && !r_dec_valid) begin
          r_dec_valid <= 1'b1;
          r_dec_gt    <= w_a_gt;
        end
      end
      if (w_complete) begin
        r_gt <= w_res_gt;
        r_eq <= w_res_eq;
        r_lt <= w_res_lt;
      end
    end
  end

  assign bus.busy         = (r_state == S_SCAN);
  assign bus.done         = r_done;
  assign bus.left_greater = r_gt;
  assign bus.equal        = r_eq;
  assign bus.left_smaller = r_lt;

endmodule

// File: tb/tb_serial_mag_cmp.sv
// Bench for serial_mag_cmp: three instances (unsigned early-exit, signed early-exit,
// unsigned fixed-latency) checked against an arithmetic reference model.
module tb_serial_mag_cmp;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  serial_mag_cmp_if #(.WIDTH(8)) u_if ();
  serial_mag_cmp_if #(.WIDTH(8)) s_if ();
  serial_mag_cmp_if #(.WIDTH(8)) f_if ();

  serial_mag_cmp #(.WIDTH(8), .SIGNED(0), .EARLY_EXIT(1)) dut_u (.clk(clk), .rst(rst), .bus(u_if));
  serial_mag_cmp #(.WIDTH(8), .SIGNED(1), .EARLY_EXIT(1)) dut_s (.clk(clk), .rst(rst), .bus(s_if));
  serial_mag_cmp #(.WIDTH(8), .SIGNED(0), .EARLY_EXIT(0)) dut_f (.clk(clk), .rst(rst), .bus(f_if));

  // Reference: flags {gt,eq,lt} from plain integer comparison.
  function automatic logic [2:0] ref_flags(input logic [7:0] a, input logic [7:0] b, input bit sgn);
    int ia, ib;
    ia = sgn ? int'($signed(a)) : int'(a);
    ib = sgn ? int'($signed(b)) : int'(b);
    if (ia > ib) return 3'b100;
    if (ia == ib) return 3'b010;
    return 3'b001;
  endfunction

  // Reference: edges from accept to completion (1 + leading equal bits, or WIDTH).
  function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b, input bit early);
    logic [7:0] x;
    x = a ^ b;
    if (!early || x == 8'h00) return 8;
    for (int i = 7; i >= 0; i--)
      if (x[i]) return 1 + (7 - i);
    return 8;
  endfunction

  task automatic set_in(input int inst, input logic st, input logic [7:0] a, input logic [7:0] b);
    case (inst)
      0: begin u_if.start = st; u_if.left = a; u_if.right = b; end
      1: begin s_if.start = st; s_if.left = a; s_if.right = b; end
      default: begin f_if.start = st; f_if.left = a; f_if.right = b; end
    endcase
  endtask

  task automatic get_out(input int inst, output logic bz, output logic dn, output logic [2:0] fl);
    case (inst)
      0: begin bz = u_if.busy; dn = u_if.done; fl = {u_if.left_greater, u_if.equal, u_if.left_smaller}; end
      1: begin bz = s_if.busy; dn = s_if.done; fl = {s_if.left_greater, s_if.equal, s_if.left_smaller}; end
      default: begin bz = f_if.busy; dn = f_if.done; fl = {f_if.left_greater, f_if.equal, f_if.left_smaller}; end
    endcase
  endtask

  // Runs one comparison; lat = edges from accept to completion, bcnt = busy cycles.
  task automatic run_op(input int inst, input logic [7:0] a, input logic [7:0] b, input bit noise,
                        output int lat, output int bcnt, output logic [2:0] fl,
                        output bit to, output bit ovl);
    logic bz, dn;
    logic [2:0] f;
    int edges;
    to = 1'b0; ovl = 1'b0; bcnt = 0; lat = -1; fl = 3'b000; edges = 0;
    @(negedge clk);
    set_in(inst, 1'b1, a, b);
    @(negedge clk);
    set_in(inst, 1'b0, a, b);
    for (int k = 0; k < 40; k++) begin
      get_out(inst, bz, dn, f);
      if (bz && dn) ovl = 1'b1;
      if (dn) begin
        lat = edges;
        fl  = f;
        set_in(inst, 1'b0, a, b);
        break;
      end
      if (bz) bcnt++;
      if (noise && bz) set_in(inst, 1'($urandom), 8'($urandom), 8'($urandom));
      @(negedge clk);
      edges++;
    end
    if (lat < 0) to = 1'b1;
  endtask

  task automatic test_reset();
    logic bz, dn, seen;
    logic [2:0] fl;
    int lat, bcnt;
    bit to, ovl;
    for (int i = 0; i < 3; i++) begin
      get_out(i, bz, dn, fl);
      total++;
      if ({bz, dn, fl} !== 5'b0) begin
        bad++;
        $display("FAIL reset_state inst%0d: got busy/done/flags=%b expected 00000", i, {bz, dn, fl});
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_in(0, 1'b1, 8'h3C, 8'h3D);
    @(negedge clk);
    set_in(0, 1'b0, 8'h3C, 8'h3D);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1 get_out(0, bz, dn, fl);
    total++;
    if ({bz, dn, fl} !== 5'b0) begin
      bad++;
      $display("FAIL reset_midscan: got busy/done/flags=%b expected 00000", {bz, dn, fl});
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      get_out(0, bz, dn, fl);
      if (dn || bz || fl != 3'b000) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL reset_no_done: got activity=%b expected 0", seen);
    end
    run_op(0, 8'h3C, 8'h3D, 1'b0, lat, bcnt, fl, to, ovl);
    total++;
    if (to || lat != 8 || fl !== 3'b001) begin
      bad++;
      $display("FAIL reset_fresh_op: got lat=%0d flags=%b to=%0d expected lat=8 flags=001", lat, fl, to);
    end
  endtask

  task automatic test_unsigned_early();
    int lat, bcnt;
    logic [2:0] fl;
    bit to, ovl;
    run_op(0, 8'hA5, 8'h25, 1'b0, lat, bcnt, fl, to, ovl);
    total++;
    if (to || lat != 1 || fl !== 3'b100 || ovl) begin
      bad++;
      $display("FAIL unsigned_early: got lat=%0d flags=%b ovl=%0d expected lat=1 flags=100 ovl=0", lat, fl, ovl);
    end
  endtask

  task automatic test_equal_latency();
    int lat, bcnt;
    logic [2:0] fl;
    bit to, ovl;
    run_op(0, 8'h3C, 8'h3C, 1'b1, lat, bcnt, fl, to, ovl);
    total++;
    if (to || lat != 8 || fl !== 3'b010) begin
      bad++;
      $display("FAIL equal_result: got lat=%0d flags=%b expected lat=8 flags=010", lat, fl);
    end
    total++;
    if (bcnt != 8 || ovl) begin
      bad++;
      $display("FAIL equal_busy: got busy_cycles=%0d ovl=%0d expected 8 and 0", bcnt, ovl);
    end
  endtask

  task automatic test_signed();
    int lat, bcnt;
    logic [2:0] fl;
    bit to, ovl;
    run_op(1, 8'h80, 8'h01, 1'b0, lat, bcnt, fl, to, ovl);
    total++;
    if (to || lat != 1 || fl !== 3'b001) begin
      bad++;
      $display("FAIL signed_80_01: got lat=%0d flags=%b expected lat=1 flags=001", lat, fl);
    end
    run_op(0, 8'h80, 8'h01, 1'b0, lat, bcnt, fl, to, ovl);
    total++;
    if (to || lat != 1 || fl !== 3'b100) begin
      bad++;
      $display("FAIL unsigned_80_01: got lat=%0d flags=%b expected lat=1 flags=100", lat, fl);
    end
  endtask

  task automatic test_fixed_latency();
    int lat, bcnt;
    logic [2:0] fl;
    bit to, ovl;
    run_op(2, 8'hF0, 8'h00, 1'b0, lat, bcnt, fl, to, ovl);
    total++;
    if (to || lat != 8 || fl !== 3'b100) begin
      bad++;
      $display("FAIL fixed_F0_00: got lat=%0d flags=%b expected lat=8 flags=100", lat, fl);
    end
    run_op(2, 8'h10, 8'h11, 1'b0, lat, bcnt, fl, to, ovl);
    total++;
    if (to || lat != 8 || fl !== 3'b001) begin
      bad++;
      $display("FAIL fixed_10_11: got lat=%0d flags=%b expected lat=8 flags=001", lat, fl);
    end
    run_op(2, 8'h80, 8'h7F, 1'b0, lat, bcnt, fl, to, ovl);
    total++;
    if (to || lat != 8 || fl !== 3'b100) begin
      bad++;
      $display("FAIL fixed_sticky_80_7F: got lat=%0d flags=%b expected lat=8 flags=100", lat, fl);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bcnt, edges, lat2;
    logic [2:0] fl, f;
    logic bz, dn, held_ok;
    bit to, ovl;
    run_op(0, 8'h01, 8'h02, 1'b0, lat, bcnt, fl, to, ovl);
    total++;
    if (to || lat != 7 || fl !== 3'b001) begin
      bad++;
      $display("FAIL b2b_first: got lat=%0d flags=%b expected lat=7 flags=001", lat, fl);
    end
    set_in(0, 1'b1, 8'h07, 8'h07);
    @(negedge clk);
    set_in(0, 1'b0, 8'h00, 8'hFF);
    edges = 0; lat2 = -1; held_ok = 1'b1; f = 3'b000;
    for (int k = 0; k < 40; k++) begin
      get_out(0, bz, dn, fl);
      if (dn) begin
        lat2 = edges;
        f = fl;
        break;
      end
      if (fl !== 3'b001 || !bz) held_ok = 1'b0;
      @(negedge clk);
      edges++;
    end
    total++;
    if (held_ok !== 1'b1) begin
      bad++;
      $display("FAIL b2b_hold: got held=%b expected 1 (busy with flags 001 until completion)", held_ok);
    end
    total++;
    if (lat2 != 8 || f !== 3'b010) begin
      bad++;
      $display("FAIL b2b_second: got lat=%0d flags=%b expected lat=8 flags=010", lat2, f);
    end
  endtask

  task automatic test_random();
    int lat, bcnt, exp_lat;
    logic [2:0] fl, exp_fl;
    logic [7:0] a, b;
    bit to, ovl, sgn, early;
    for (int inst = 0; inst < 3; inst++) begin
      sgn   = (inst == 1);
      early = (inst != 2);
      for (int n = 0; n < 30; n++) begin
        a = 8'($urandom);
        case ($urandom_range(3))
          0: b = a;
          1: b = a ^ (8'h01 << $urandom_range(7));
          default: b = 8'($urandom);
        endcase
        exp_fl  = ref_flags(a, b, sgn);
        exp_lat = ref_lat(a, b, early);
        run_op(inst, a, b, 1'($urandom), lat, bcnt, fl, to, ovl);
        total++;
        if (to || fl !== exp_fl || lat != exp_lat || bcnt != exp_lat || ovl) begin
          bad++;
          $display("FAIL random inst%0d a=%h b=%h: got flags=%b lat=%0d busy=%0d ovl=%0d to=%0d expected flags=%b lat=%0d",
                   inst, a, b, fl, lat, bcnt, ovl, to, exp_fl, exp_lat);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) set_in(i, 1'b0, 8'h00, 8'h00);
    #12;
    test_reset();
    test_unsigned_early();
    test_equal_latency();
    test_signed();
    test_fixed_latency();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_mag_cmp.md
# serial_mag_cmp

Parametrised, bit-serial magnitude comparator. It is the sequential successor to the team's combinational 3-bit comparator. The block latches two WIDTH-bit operands on a start strobe and compares them MSB-first, one bit per clock. It reports greater, equal or smaller as registered one-hot flags, with a done pulse. It serves lab datapaths that trade latency for area and need a start/busy/done handshake.

## Interface
- WIDTH, 8, operand width in bits; legal range ≥ 2.
- SIGNED, 0: 0 compares as unsigned; 1 compares as two's complement.
- EARLY_EXIT, 1: 1 ends the operation at the first differing bit; 0 always scans all WIDTH bits, giving fixed latency.
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- left  in  WIDTH  operand A; sampled on the accepting edge only.
- right  in  WIDTH  operand B; sampled on the accepting edge only.
- busy  out  1  comparison in progress.
- done  out  1  one-cycle pulse: result flags just updated.
- left_greater  out  1  A > B for the last completed comparison.
- equal  out  1  A == B for the last completed comparison.
- left_smaller  out  1  A < B for the last completed comparison.

## Operation
- Two states:
  - IDLE: busy=0.
  - SCAN: busy=1.
- IDLE with start=1:
  - Latch left/right into shift registers.
  - Bit index := WIDTH-1; clear the sticky decision.
  - Go to SCAN.
- SCAN, each cycle: compare the current MSB of both shift registers.
  - Unsigned, bits differ: A_bit=1 means greater, otherwise smaller.
  - SIGNED=1, first scanned bit (sign bit) only: the sense is inverted. A_bit=1, B_bit=0 means smaller.
- EARLY_EXIT=1:
  - The first difference writes the flags, pulses done and returns to IDLE.
  - If index 0 is reached with no difference, the result is equal.
- EARLY_EXIT=0:
  - The first difference is stored in a sticky register; later bits never override it.
  - Completion happens at index 0 only; flags come from the sticky value, or equal if no difference was found.
- Shift both registers left by one and decrement the index each SCAN cycle without completion.
- Result flags:
  - They change only on completion, are exactly one-hot after the first completion, and hold until the next completion.
  - start, left and right are ignored while busy=1; the operands are already latched.

## Timing
- Reset (async assert, synchronous-edge release): state=IDLE; busy=0, done=0, left_greater=0, equal=0, left_smaller=0; shift registers, index and sticky decision are cleared.
- Reset mid-SCAN: the operation is aborted immediately, with no done pulse and no flag update.
- Edge numbering: start accepted on edge E0; busy is high from E0.
- Let p = number of leading equal bits, 0 ≤ p ≤ WIDTH-1 (for an equal result, p = WIDTH-1).
  - EARLY_EXIT=1: completion edge is E0+1+p.
  - EARLY_EXIT=0: completion edge is always E0+WIDTH.
- On the completion edge:
  - Flags update.
  - done=1 for exactly the following cycle.
  - busy=0 in that same cycle.
- Back-to-back: start=1 during the done cycle is accepted. Busy goes high again on the next edge; flags hold the previous result until the new completion.
- Throughput: at most one comparison per 2 cycles (early exit, p=0). Worst case is WIDTH+1 cycles start-to-start.
- done and busy are never high together.

## Test plan
- Reset: assert rst mid-SCAN (A=8'h3C, B=8'h3D, 3 cycles in). Required: busy, done and all flags are 0 immediately, and no done pulse follows. A fresh start after release completes normally.
- Unsigned early exit, WIDTH=8: A=8'hA5, B=8'h25, start at E0. Required: done during the cycle after E0+1, left_greater=1, other flags 0.
- Equal and full latency: A=B=8'h3C. Required: done after E0+8, equal=1. busy is high for exactly 8 cycles. A start pulsed mid-scan with other operands is ignored.
- Signed, SIGNED=1: A=8'h80 (-128), B=8'h01. Required: left_smaller=1 with done after E0+1. Unsigned instance, same operands: left_greater=1.
- Fixed latency, EARLY_EXIT=0:
  - A=8'hF0, B=8'h00: done after E0+8, left_greater=1; later equal bits do not override the sticky decision.
  - A=8'h10, B=8'h11: done after E0+8, left_smaller=1.
- Back-to-back: first A=8'h01, B=8'h02. Assert start in its done cycle with A=8'h07, B=8'h07. Required: left_smaller holds until the second completion at +8 edges, then the flags switch to equal=1.
